cpu_mc: RTL and testbench
=========================

# cpu_mc

Multi-cycle, parametrised RV32I-subset core: the next generation of the single-cycle cpu top. Fetch, decode, execute, memory and writeback run as sequential FSM states sharing one ALU. Instruction and data traffic use one external memory port with a req/ack handshake, so wait-state memories are supported. Adds branches, jumps, LUI/AUIPC, and an optional illegal-instruction trap.

## Interface
- n, 32, datapath/register width; legal values 32 or 64
- RESET_PC, 0, first fetch address after reset
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  memory request; held until acked
- mem_we  out  1  1 = store, 0 = read (fetch or load)
- mem_addr  out  n  byte address; bits [1:0] always 0
- mem_wdata  out  n  store data (rs2)
- mem_rdata  in  n  read data; instruction is bits [31:0]
- mem_ack  in  1  request completes on the clock edge where req && ack
- outport  out  n  last value written to a nonzero rd
- halted  out  1  trap taken (only with CPU_MC_TRAP_EN)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is from the package.
- FETCH: req=1, we=0, addr=pc. On ack: ir<=rdata[31:0], go DECODE.
- DECODE: latch A<=x[rs1], B<=x[rs2], imm<=immgen(ir).
- EXEC:
  - OP/OP-IMM/LUI/AUIPC: alu result -> WB.
  - LOAD/STORE: addr=A+imm -> MEM.
  - BRANCH: pc<=taken ? pc+imm : pc+4 -> FETCH.
  - JAL: target pc+imm. JALR: target (A+imm)&~1. Both: result=pc+4 -> WB.
- MEM: req=1; we=1 for store. Addr is latched, with [1:0] forced 0. On ack: load data -> WB, store -> FETCH with pc+=4.
- WB: write rd unless rd==0; outport<=value. pc<=jump target, or pc+4 for everything else. Go FETCH.
- ALU ops: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - Shift amount = low $clog2(n) bits of B/imm.
  - SUB/SRA selected by funct7[5] (SRAI by imm[10]).
- Branches: BEQ BNE BLT BGE BLTU BGEU.
- Width rules:
  - Immediates are sign-extended to n.
  - LUI/AUIPC upper immediate is sign-extended from bit 31.
  - pc and address arithmetic wrap modulo 2^n.
- Loads/stores are word only (funct3 ignored beyond class).
- x0 reads 0; writes to x0 are discarded.

## Timing
- Reset asserted: pc=RESET_PC, state=FETCH, regs=0, outport=0, halted=0, mem_req=0. mem_req deasserts asynchronously.
- First mem_req=1 is in the first cycle after reset release.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while req=1 and ack=0.
  - req drops the cycle after the ack edge.
  - ack while req=0 is ignored.
  - One outstanding request at most.
- Latency with ack in the first request cycle: branch 3 cycles; ALU/LUI/AUIPC/JAL/JALR 4; store 4; load 5. Each wait cycle adds one.
- Reset mid-request: the transaction is abandoned and no register or pc update occurs.

## Configuration
- CPU_MC_TRAP_EN defined:
  - Unrecognised opcode in EXEC enters HALT.
  - In HALT: halted=1, mem_req=0, pc frozen; only reset exits.
- Not defined:
  - Unrecognised opcodes execute as NOP (pc+=4, via WB with no write).
  - halted is tied 0 and there is no HALT state.

## Structure
- Package cpu_mc_pkg holds:
  - state enum
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - alu op enum
  - funct3 branch codes
- Sub-module immgen (combinational): ir -> n-bit I/S/B/U/J immediate, selected by opcode.
- Register file and ALU are inline in cpu_mc.

## Test plan
- Reset low 3 cycles, then release -> next cycle mem_req=1, mem_addr=0, mem_we=0; outport=0, halted=0.
- Zero-wait fetch of 0x00500093 (ADDI x1,x0,5), then 0x00108133 (ADD x2,x1,x1) -> outport=5 at cycle 4, 10 at cycle 8; second fetch addr=4.
- 0x00202423 (SW x2,8(x0)) -> MEM cycle shows mem_we=1, addr=8, wdata=10. Then 0x00802183 (LW x3,8(x0)) with rdata=10 -> outport=10, 5 cycles.
- 0xFE000CE3 (BEQ x0,x0,-8) at pc 0x10 -> next fetch addr 0x08 after 3 cycles. BNE x0,x0 at 0x10 -> next fetch 0x14.
- Ack delayed 3 cycles on fetch and on load -> addr/we/wdata stable throughout, no state advance, final result unchanged.
- Instruction 0x00000000:
  - With CPU_MC_TRAP_EN: halted=1, mem_req stays 0 for 20 cycles; reset clears it.
  - Without the macro: next fetch at pc+4, no register write.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// Shared types and encodings for the cpu_mc multi-cycle core.
// CPU_MC_TRAP_EN adds the HALT state used by the illegal-instruction trap.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef CPU_MC_TRAP_EN
    , ST_HALT = 3'd5
`endif
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Non-arithmetic classes (address, LUI, AUIPC) all reduce to ADD.
  function automatic alu_op_e alu_decode(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic b30);
    alu_op_e op;
    op = ALU_ADD;
    if (opc == OPC_OP || opc == OPC_OP_IMM) begin
      case (f3)
        3'b000:  op = (opc == OPC_OP && b30) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/cpu_mc_immgen.sv
// Immediate generator: picks the I/S/B/U/J form by opcode and sign-extends to n bits.
module cpu_mc_immgen
  import cpu_mc_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [31:0]  i_ir,
  output logic [n-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_ir[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
      OPC_STORE:
        w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      OPC_BRANCH:
        w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm32 = {i_ir[31:12], 12'b0};
      OPC_JAL:
        w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      default: ;
    endcase
  end

  assign o_imm = n'($signed(w_imm32));

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I-subset core with one shared req/ack memory port.
// Define CPU_MC_TRAP_EN to halt on unrecognised opcodes instead of treating them as NOPs.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int            n        = 32,
  parameter logic [n-1:0]  RESET_PC = '0
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [n-1:0] o_mem_addr,
  output logic [n-1:0] o_mem_wdata,
  input  logic [n-1:0] i_mem_rdata,
  input  logic         i_mem_ack,
  output logic [n-1:0] o_outport,
  output logic         o_halted
);

  localparam int SHW = $clog2(n);

  state_e       r_state, w_next;
  logic         r_go;
  logic [31:0]  r_ir;
  logic [n-1:0] r_pc, r_a, r_b, r_imm, r_res, r_addr, r_tgt, r_out;
  logic         r_wen, r_jmp;
  logic [n-1:0] r_x [32];

  logic [6:0]   w_opc;
  logic [2:0]   w_f3;
  logic [4:0]   w_rd, w_rs1, w_rs2;
  logic [n-1:0] w_imm, w_op_a, w_op_b, w_alu, w_pc4, w_pcimm, w_addr;
  logic [SHW-1:0] w_sh;
  alu_op_e      w_alu_op;
  logic         w_take, w_req, w_hs;

  assign w_opc = r_ir[6:0];
  assign w_f3  = r_ir[14:12];
  assign w_rd  = r_ir[11:7];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];

  cpu_mc_immgen #(.n(n)) u_immgen (.i_ir(r_ir), .o_imm(w_imm));

  assign w_pc4   = r_pc + n'(4);
  assign w_pcimm = r_pc + r_imm;

  always_comb begin
    w_op_a = r_a;
    w_op_b = r_imm;
    case (w_opc)
      OPC_OP:    w_op_b = r_b;
      OPC_LUI:   w_op_a = '0;
      OPC_AUIPC: w_op_a = r_pc;
      default: ;
    endcase
    w_alu_op = alu_decode(w_opc, w_f3, r_ir[30]);
    w_sh     = w_op_b[SHW-1:0];
    case (w_alu_op)
      ALU_ADD:  w_alu = w_op_a + w_op_b;
      ALU_SUB:  w_alu = w_op_a - w_op_b;
      ALU_SLL:  w_alu = w_op_a << w_sh;
      ALU_SLT:  w_alu = n'($signed(w_op_a) < $signed(w_op_b));
      ALU_SLTU: w_alu = n'(w_op_a < w_op_b);
      ALU_XOR:  w_alu = w_op_a ^ w_op_b;
      ALU_SRL:  w_alu = w_op_a >> w_sh;
      ALU_SRA:  w_alu = $unsigned($signed(w_op_a) >>> w_sh);
      ALU_OR:   w_alu = w_op_a | w_op_b;
      default:  w_alu = w_op_a & w_op_b;
    endcase
  end

  always_comb begin
    case (w_f3)
      F3_BEQ:  w_take = (r_a == r_b);
      F3_BNE:  w_take = (r_a != r_b);
      F3_BLT:  w_take = ($signed(r_a) <  $signed(r_b));
      F3_BGE:  w_take = ($signed(r_a) >= $signed(r_b));
      F3_BLTU: w_take = (r_a <  r_b);
      F3_BGEU: w_take = (r_a >= r_b);
      default: w_take = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_FETCH;
    else            r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (w_hs) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        case (w_opc)
          OPC_LOAD, OPC_STORE: w_next = ST_MEM;
          OPC_BRANCH:          w_next = ST_FETCH;
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                               w_next = ST_WB;
`ifdef CPU_MC_TRAP_EN
          default:             w_next = ST_HALT;
`else
          default:             w_next = ST_WB;
`endif
        endcase
      end
      ST_MEM:    if (w_hs) w_next = (w_opc == OPC_STORE) ? ST_FETCH : ST_WB;
      ST_WB:     w_next = ST_FETCH;
      default:   w_next = r_state;
    endcase
  end

  // FSM: outputs. r_go holds off the first request until a clock after reset release.
  always_comb begin
    w_req    = 1'b0;
    o_mem_we = 1'b0;
    w_addr   = r_pc;
    case (r_state)
      ST_FETCH: w_req = r_go;
      ST_MEM: begin
        w_req    = 1'b1;
        o_mem_we = (w_opc == OPC_STORE);
        w_addr   = r_addr;
      end
      default: ;
    endcase
  end

  assign w_hs        = w_req & i_mem_ack;
  assign o_mem_req   = w_req;
  assign o_mem_addr  = {w_addr[n-1:2], 2'b00};
  assign o_mem_wdata = r_b;
  assign o_outport   = r_out;
`ifdef CPU_MC_TRAP_EN
  assign o_halted    = (r_state == ST_HALT);
`else
  assign o_halted    = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_go   <= 1'b0;
      r_pc   <= RESET_PC;
      r_ir   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_imm  <= '0;
      r_res  <= '0;
      r_addr <= '0;
      r_tgt  <= '0;
      r_out  <= '0;
      r_wen  <= 1'b0;
      r_jmp  <= 1'b0;
      for (int i = 0; i < 32; i++) r_x[i] <= '0;
    end else begin
      r_go <= 1'b1;
      case (r_state)
        ST_FETCH: if (w_hs) r_ir <= i_mem_rdata[31:0];
        ST_DECODE: begin
          r_a   <= r_x[w_rs1];
          r_b   <= r_x[w_rs2];
          r_imm <= w_imm;
        end
        ST_EXEC: begin
          r_res  <= w_alu;
          r_addr <= w_alu;
          r_wen  <= 1'b0;
          r_jmp  <= 1'b0;
          case (w_opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: r_wen <= 1'b1;
            OPC_BRANCH: r_pc <= w_take ? w_pcimm : w_pc4;
            OPC_JAL: begin
              r_wen <= 1'b1;
              r_jmp <= 1'b1;
              r_res <= w_pc4;
              r_tgt <= w_pcimm;
            end
            OPC_JALR: begin
              r_wen <= 1'b1;
              r_jmp <= 1'b1;
              r_res <= w_pc4;
              r_tgt <= {w_alu[n-1:1], 1'b0};
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (w_hs && w_opc == OPC_STORE) begin
            r_pc <= w_pc4;
          end else if (w_hs) begin
            r_res <= i_mem_rdata;
            r_wen <= 1'b1;
          end
        end
        ST_WB: begin
          // x0 is never written, so it reads back as zero without a read-side guard.
          if (r_wen && w_rd != 5'd0) begin
            r_x[w_rd] <= r_res;
            r_out     <= r_res;
          end
          r_pc <= r_jmp ? r_tgt : w_pc4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: the bench plays the memory, feeding each fetch by hand.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we, halted;
  logic        ack = 1'b0;
  logic [31:0] addr, wdata, outp;
  logic [31:0] rdata = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cpu_mc #(.n(32), .RESET_PC(32'h0)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .o_mem_req  (req),
    .o_mem_we   (we),
    .o_mem_addr (addr),
    .o_mem_wdata(wdata),
    .i_mem_rdata(rdata),
    .i_mem_ack  (ack),
    .o_outport  (outp),
    .o_halted   (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a request (gap = idle cycles first), check it, hold ack low for
  // `waits` cycles checking stability, then complete it with rd.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                       input logic [31:0] exp_wd, input int waits, input logic [31:0] rd,
                       input int exp_gap);
    int gap;
    gap = 0;
    while (req !== 1'b1 && gap < 50) begin
      step();
      gap++;
    end
    chk({tag, "_gap"}, gap, exp_gap);
    chk({tag, "_addr"}, addr, exp_addr);
    chk({tag, "_we"}, {31'b0, we}, {31'b0, exp_we});
    if (exp_we) chk({tag, "_wdata"}, wdata, exp_wd);
    for (int i = 0; i < waits; i++) begin
      rdata = $urandom;
      step();
      chk({tag, "_hold_req"}, {31'b0, req}, 32'd1);
      chk({tag, "_hold_addr"}, addr, exp_addr);
      chk({tag, "_hold_we"}, {31'b0, we}, {31'b0, exp_we});
      if (exp_we) chk({tag, "_hold_wdata"}, wdata, exp_wd);
    end
    ack   = 1'b1;
    rdata = rd;
    step();
    ack   = 1'b0;
    rdata = $urandom;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_out", outp, 32'd0);
    chk("rst_halt", {31'b0, halted}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("boot_req", {31'b0, req}, 32'd1);
    chk("boot_out", outp, 32'd0);

    serve("f_addi",  32'h00, 1'b0, 0, 0, 32'h00500093, 0);
    serve("f_add",   32'h04, 1'b0, 0, 0, 32'h00108133, 3);
    chk("out_addi", outp, 32'd5);
    serve("f_sw",    32'h08, 1'b0, 0, 0, 32'h00202423, 3);
    chk("out_add", outp, 32'd10);
    serve("m_sw",    32'h08, 1'b1, 32'd10, 0, 32'h0, 2);
    serve("f_lw",    32'h0C, 1'b0, 0, 3, 32'h00802183, 0);
    serve("m_lw",    32'h08, 1'b0, 0, 3, 32'd10, 2);
    serve("f_beq",   32'h10, 1'b0, 0, 0, 32'hFE000CE3, 1);
    chk("out_lw", outp, 32'd10);
    serve("f_add4",  32'h08, 1'b0, 0, 0, 32'h00118233, 2);
    serve("f_sub",   32'h0C, 1'b0, 0, 0, 32'h402082B3, 3);
    chk("out_add4", outp, 32'd15);
    serve("f_bne",   32'h10, 1'b0, 0, 0, 32'hFE001CE3, 3);
    chk("out_sub", outp, 32'hFFFFFFFB);
    serve("f_lui",   32'h14, 1'b0, 0, 0, 32'h80000337, 2);
    serve("f_auipc", 32'h18, 1'b0, 0, 0, 32'h00001397, 3);
    chk("out_lui", outp, 32'h80000000);
    serve("f_jal",   32'h1C, 1'b0, 0, 0, 32'h0100046F, 3);
    chk("out_auipc", outp, 32'h00001018);
    serve("f_jalr",  32'h2C, 1'b0, 0, 0, 32'h03C084E7, 3);
    chk("out_jal", outp, 32'h00000020);
    serve("f_srai",  32'h40, 1'b0, 0, 0, 32'h4012D513, 3);
    chk("out_jalr", outp, 32'h00000030);
    serve("f_sltu",  32'h44, 1'b0, 0, 0, 32'h005035B3, 3);
    chk("out_srai", outp, 32'hFFFFFFFD);
    serve("f_srl",   32'h48, 1'b0, 0, 0, 32'h0012D633, 3);
    chk("out_sltu", outp, 32'd1);
    serve("f_x0",    32'h4C, 1'b0, 0, 0, 32'h00700013, 3);
    chk("out_srl", outp, 32'h07FFFFFF);
    serve("f_ill",   32'h50, 1'b0, 0, 0, 32'h00000000, 3);
    chk("out_x0", outp, 32'h07FFFFFF);

`ifdef CPU_MC_TRAP_EN
    step();
    step();
    chk("trap_halted", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      ack = 1'b1;
      step();
      chk("trap_req", {31'b0, req}, 32'd0);
    end
    ack   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("trap_rst_halt", {31'b0, halted}, 32'd0);
    step();
`else
    serve("f_add13", 32'h54, 1'b0, 0, 0, 32'h001006B3, 3);
    chk("out_ill", outp, 32'h07FFFFFF);
    chk("ill_halt", {31'b0, halted}, 32'd0);
    serve("f_nop",   32'h58, 1'b0, 0, 0, 32'h00000013, 3);
    chk("out_add13", outp, 32'd5);
    repeat (3) step();
    chk("mid_req", {31'b0, req}, 32'd1);
    chk("mid_addr", addr, 32'h5C);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, req}, 32'd0);
    chk("mid_rst_out", outp, 32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
`endif

    rst_n = 1'b1;
    step();
    chk("boot2_req", {31'b0, req}, 32'd1);
    serve("f_post",  32'h00, 1'b0, 0, 0, 32'h00310793, 0);
    serve("f_post2", 32'h04, 1'b0, 0, 0, 32'h00000013, 3);
    chk("out_post", outp, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
